// File: rtl/stm32h7_pssi_pkg.sv
// Shared constants and types for the STM32H7 PSSI 8-bit bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stm32h7_pssi_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

    // DE is active-low on the PSSI bus: 0 marks a valid byte.
    localparam logic DE_ACTIVE = 1'b0;
    localparam logic DE_IDLE   = 1'b1;

    // TX byte index runs 0..BYTES_PER_WORD, the extra value marks
    // "all bytes driven, holding the last one".
    localparam int               TX_IDX_W = 3;
    localparam logic [TX_IDX_W-1:0] TX_IDX_END = TX_IDX_W'(BYTES_PER_WORD);

    // RX lane counter: 0..BYTES_PER_WORD-1.
    localparam int         RX_CNT_W = 2;
    localparam logic [RX_CNT_W-1:0] RX_CNT_LAST = RX_CNT_W'(BYTES_PER_WORD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Little-endian lane select: lane 0 is bits [7:0].
    function automatic logic [BYTE_W-1:0] get_lane(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane);
        logic [BYTE_W-1:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/stm32h7_pssi_8bus_32bits_if_clk_gen.sv
// PSSI clock divider: pssi_clk_o = clk_i / CLK_DIV, 50% duty, first toggle to 1.
// Latency: first rising toggle CLK_DIV/2 clk_i cycles after reset release.
// Backpressure: none, free-running.
module pssi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pssi_clk_o,
    output logic rise_evt_o,
    output logic fall_evt_o
);

    // CLK_DIV is expected even and >= 2; half-period in clk_i cycles.
    localparam int HALF = (CLK_DIV / 2 < 1) ? 1 : CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pssi_clk_q, pssi_clk_d;
    logic          tick;

    // Half-period counter and clock toggle next-state.
    always_comb begin
        tick       = (div_cnt_q == DW'(HALF - 1));
        div_cnt_d  = tick ? '0 : div_cnt_q + DW'(1);
        pssi_clk_d = tick ? ~pssi_clk_q : pssi_clk_q;
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q  <= '0;
            pssi_clk_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            pssi_clk_q <= pssi_clk_d;
        end
    end

    // Events flag the clk_i cycle whose closing edge flips the clock register.
    assign rise_evt_o = tick & ~pssi_clk_q;
    assign fall_evt_o = tick &  pssi_clk_q;
    assign pssi_clk_o = pssi_clk_q;

endmodule

// File: rtl/stm32h7_pssi_8bus_32bits_if.sv
// FPGA-side STM32H7 PSSI bridge: 8-bit bus packed to/from 32-bit words.
// Latency: RX word visible on the clk_i edge that samples its 4th byte; TX starts on next pssi fall.
// Backpressure: tx_ready_o low while a word is being serialised; RX has none.
module stm32h7_pssi_8bus_32bits_if #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        pssi_clk_o,
    inout  wire         pssi_de_io,
    inout  wire  [7:0]  pssi_data_io,
    output logic [31:0] fpga_data_o,
    output logic        rx_valid_o,
    input  logic        tx_en_i,
    input  logic [31:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o
);
    import stm32h7_pssi_pkg::*;

    logic rise_evt, fall_evt;

    pssi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pssi_clk_o (pssi_clk_o),
        .rise_evt_o (rise_evt),
        .fall_evt_o (fall_evt)
    );

    // ---------------------------------------------------------------
    // TX serialiser FSM
    // ---------------------------------------------------------------
    tx_state_e             tx_state_q, tx_state_d;
    logic [WORD_W-1:0]     tx_word_q, tx_word_d;
    logic [TX_IDX_W-1:0]   tx_idx_q, tx_idx_d;
    logic                  tx_de_q, tx_de_d;
    logic [BYTE_W-1:0]     tx_byte_q, tx_byte_d;
    logic                  tx_seen_rise_q, tx_seen_rise_d;

    logic                  tx_ready;
    logic                  tx_accept;
    logic                  pin_drive;
    logic                  pin_de;
    logic [BYTE_W-1:0]     pin_data;
    logic                  rx_en;

    assign tx_accept = tx_valid_i & tx_ready & tx_en_i;

    // TX state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= IDLE;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    // TX next state: leave SEND only once the last byte saw a full pssi period.
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            IDLE: begin
                if (tx_accept) begin
                    tx_state_d = SEND;
                end
            end
            SEND: begin
                if (fall_evt && (tx_idx_q == TX_IDX_END) && tx_seen_rise_q) begin
                    tx_state_d = IDLE;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // TX outputs: idle drive follows tx_en_i live; SEND always owns the pins.
    always_comb begin
        tx_ready  = 1'b0;
        pin_drive = 1'b0;
        pin_de    = DE_IDLE;
        pin_data  = '0;
        rx_en     = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_ready  = 1'b1;
                pin_drive = tx_en_i;
                rx_en     = ~tx_en_i;
            end
            SEND: begin
                pin_drive = 1'b1;
                pin_de    = tx_de_q;
                pin_data  = tx_byte_q;
            end
            default: begin
                tx_ready = 1'b0;
            end
        endcase
    end

    // TX datapath next-state: bytes change on pssi falling edges so the MCU
    // samples them mid-bit on the rising edge.
    always_comb begin
        tx_word_d      = tx_word_q;
        tx_idx_d       = tx_idx_q;
        tx_de_d        = tx_de_q;
        tx_byte_d      = tx_byte_q;
        tx_seen_rise_d = tx_seen_rise_q;
        if (tx_accept) begin
            tx_word_d      = tx_data_i;
            tx_idx_d       = '0;
            tx_de_d        = DE_IDLE;
            tx_byte_d      = '0;
            tx_seen_rise_d = 1'b0;
        end else if (tx_state_q == SEND) begin
            if (fall_evt) begin
                if (tx_idx_q < TX_IDX_END) begin
                    tx_byte_d      = get_lane(tx_word_q, tx_idx_q[1:0]);
                    tx_de_d        = DE_ACTIVE;
                    tx_idx_d       = tx_idx_q + TX_IDX_W'(1);
                    tx_seen_rise_d = 1'b0;
                end else if (tx_seen_rise_q) begin
                    tx_de_d   = DE_IDLE;
                    tx_byte_d = '0;
                end
            end
            // The MCU has latched the last byte once a rising edge passes.
            if (rise_evt && (tx_idx_q == TX_IDX_END)) begin
                tx_seen_rise_d = 1'b1;
            end
        end
    end

    // TX datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_word_q      <= '0;
            tx_idx_q       <= '0;
            tx_de_q        <= DE_IDLE;
            tx_byte_q      <= '0;
            tx_seen_rise_q <= 1'b0;
        end else begin
            tx_word_q      <= tx_word_d;
            tx_idx_q       <= tx_idx_d;
            tx_de_q        <= tx_de_d;
            tx_byte_q      <= tx_byte_d;
            tx_seen_rise_q <= tx_seen_rise_d;
        end
    end

    assign tx_ready_o = tx_ready;

    // ---------------------------------------------------------------
    // Tri-state pin buffers
    // ---------------------------------------------------------------
    assign pssi_de_io   = pin_drive ? pin_de   : 1'bz;
    assign pssi_data_io = pin_drive ? pin_data : 8'bz;

    // ---------------------------------------------------------------
    // RX packer
    // ---------------------------------------------------------------
    logic [RX_CNT_W-1:0]               rx_cnt_q, rx_cnt_d;
    logic [(BYTES_PER_WORD-1)*8-1:0]   rx_lanes_q, rx_lanes_d;
    logic [WORD_W-1:0]                 fpga_data_q, fpga_data_d;
    logic                              rx_valid_q, rx_valid_d;

    // RX next-state: sample on pssi fall; DE high or loss of bus ownership
    // drops any partial word, the published word only changes on completion.
    always_comb begin
        rx_cnt_d    = rx_cnt_q;
        rx_lanes_d  = rx_lanes_q;
        fpga_data_d = fpga_data_q;
        rx_valid_d  = 1'b0;
        if (!rx_en) begin
            rx_cnt_d = '0;
        end else if (fall_evt) begin
            if (pssi_de_io == DE_ACTIVE) begin
                if (rx_cnt_q == RX_CNT_LAST) begin
                    fpga_data_d = {pssi_data_io, rx_lanes_q};
                    rx_valid_d  = 1'b1;
                    rx_cnt_d    = '0;
                end else begin
                    case (rx_cnt_q)
                        2'd0:    rx_lanes_d[7:0]   = pssi_data_io;
                        2'd1:    rx_lanes_d[15:8]  = pssi_data_io;
                        default: rx_lanes_d[23:16] = pssi_data_io;
                    endcase
                    rx_cnt_d = rx_cnt_q + RX_CNT_W'(1);
                end
            end else begin
                rx_cnt_d = '0;
            end
        end
    end

    // RX registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_cnt_q    <= '0;
            rx_lanes_q  <= '0;
            fpga_data_q <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            rx_cnt_q    <= rx_cnt_d;
            rx_lanes_q  <= rx_lanes_d;
            fpga_data_q <= fpga_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign fpga_data_o = fpga_data_q;
    assign rx_valid_o  = rx_valid_q;

endmodule

// File: tb/tb_stm32h7_pssi_8bus_32bits_if.sv
// Directed bench for the PSSI bridge: MCU-side bus model plus inline checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_stm32h7_pssi_8bus_32bits_if;

    logic        clk;
    logic        rst_n;
    logic        pssi_clk;
    wire         pssi_de;
    wire  [7:0]  pssi_data;
    logic [31:0] fpga_data;
    logic        rx_valid;
    logic        tx_en;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // MCU side of the bus
    logic        tb_drv;
    logic        tb_de;
    logic [7:0]  tb_dat;

    int asserts;
    int fails;

    logic [31:0] rx_q[$];

    assign pssi_de   = tb_drv ? tb_de  : 1'bz;
    assign pssi_data = tb_drv ? tb_dat : 8'bz;

    // Pull-ups make an undriven bus read as all ones.
    pullup pu_de (pssi_de);
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup pu_d (pssi_data[gi]);
    end

    stm32h7_pssi_8bus_32bits_if #(
        .CLK_DIV (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pssi_clk_o   (pssi_clk),
        .pssi_de_io   (pssi_de),
        .pssi_data_io (pssi_data),
        .fpga_data_o  (fpga_data),
        .rx_valid_o   (rx_valid),
        .tx_en_i      (tx_en),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every cycle rx_valid is high together with the published word.
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(fpga_data);
    end

    // Wait for the first negedge of clk that sees pssi_clk high after low.
    task automatic wait_rise();
        bit seen_low;
        seen_low = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!pssi_clk) seen_low = 1'b1;
            else if (seen_low) return;
        end
        asserts++;
        fails++;
        $display("FAIL wait_rise: pssi_clk_o rising edge not seen within 40 cycles");
    endtask

    // MCU launches one bus beat just after a pssi rising edge.
    task automatic send_beat(input logic de, input logic [7:0] b);
        wait_rise();
        tb_drv = 1'b1;
        tb_de  = de;
        tb_dat = b;
    endtask

    task automatic end_burst();
        wait_rise();
        tb_de  = 1'b1;
        tb_dat = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        time t_a, t_b;
        rst_n = 1'b0; tb_drv = 1'b0; tb_de = 1'b1; tb_dat = 8'h00;
        tx_en = 1'b0; tx_data = 32'h0; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        asserts++; if (pssi_clk !== 1'b0) begin fails++; $display("FAIL reset_pssi_clk: got %b want 0", pssi_clk); end
        asserts++; if (fpga_data !== 32'h0) begin fails++; $display("FAIL reset_fpga_data: got %h want 00000000", fpga_data); end
        asserts++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        asserts++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        asserts++; if (pssi_de !== 1'b1) begin fails++; $display("FAIL reset_de_hiz: got %b want 1 (pulled)", pssi_de); end
        asserts++; if (pssi_data !== 8'hFF) begin fails++; $display("FAIL reset_data_hiz: got %h want ff (pulled)", pssi_data); end
        rst_n = 1'b1;
        @(negedge clk);
        t_a = $time;
        asserts++; if (pssi_clk !== 1'b1) begin fails++; $display("FAIL first_edge_rising: got %b want 1", pssi_clk); end
        @(negedge clk);
        asserts++; if (pssi_clk !== 1'b0) begin fails++; $display("FAIL clk_second_half: got %b want 0", pssi_clk); end
        @(negedge clk);
        t_b = $time;
        asserts++; if (pssi_clk !== 1'b1 || (t_b - t_a) != 20) begin
            fails++; $display("FAIL pssi_period: level %b period %0t want 1 and 20", pssi_clk, t_b - t_a);
        end
    endtask

    task automatic test_single_word();
        rx_q.delete();
        send_beat(1'b0, 8'h1A);
        send_beat(1'b0, 8'h2B);
        send_beat(1'b0, 8'h3C);
        send_beat(1'b0, 8'h4D);
        end_burst();
        asserts++; if (rx_q.size() != 1) begin fails++; $display("FAIL single_pulses: got %0d want 1", rx_q.size()); end
        asserts++; if (rx_q.size() < 1 || rx_q[0] !== 32'h4D3C2B1A) begin
            fails++; $display("FAIL single_word: got %h want 4d3c2b1a", (rx_q.size() > 0) ? rx_q[0] : 32'hx);
        end
        asserts++; if (fpga_data !== 32'h4D3C2B1A) begin fails++; $display("FAIL single_hold: got %h want 4d3c2b1a", fpga_data); end
    endtask

    task automatic test_back_to_back();
        rx_q.delete();
        for (int i = 1; i <= 8; i++) send_beat(1'b0, 8'(i));
        end_burst();
        asserts++; if (rx_q.size() != 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", rx_q.size()); end
        asserts++; if (rx_q.size() < 2 || rx_q[0] !== 32'h04030201 || rx_q[1] !== 32'h08070605) begin
            fails++; $display("FAIL b2b_words: got %h %h want 04030201 08070605",
                              (rx_q.size() > 0) ? rx_q[0] : 32'hx, (rx_q.size() > 1) ? rx_q[1] : 32'hx);
        end
    endtask

    task automatic test_abort_partial();
        rx_q.delete();
        send_beat(1'b0, 8'hAA);
        send_beat(1'b0, 8'hBB);
        send_beat(1'b1, 8'h99);
        asserts++; if (fpga_data !== 32'h08070605) begin fails++; $display("FAIL abort_hold: got %h want 08070605", fpga_data); end
        send_beat(1'b0, 8'h11);
        send_beat(1'b0, 8'h22);
        send_beat(1'b0, 8'h33);
        send_beat(1'b0, 8'h44);
        end_burst();
        asserts++; if (rx_q.size() != 1 || rx_q[0] !== 32'h44332211) begin
            fails++; $display("FAIL abort_word: got %0d words first %h want 1 word 44332211",
                              rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'hx);
        end
    endtask

    task automatic test_tx();
        logic [7:0] seen[$];
        int         low_cnt;
        bit         done;
        rx_q.delete();
        tb_drv = 1'b0;
        tx_en  = 1'b1;
        @(negedge clk);
        asserts++; if (pssi_de !== 1'b1 || pssi_data !== 8'h00) begin
            fails++; $display("FAIL tx_idle_drive: got de %b data %h want 1 00", pssi_de, pssi_data);
        end
        tx_data  = 32'hDEADBEEF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        asserts++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL tx_ready_drop: got %b want 0", tx_ready); end
        low_cnt = 0;
        done    = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (tx_ready) done = 1'b1;
            else begin
                if (pssi_de === 1'b0) low_cnt++;
                if (pssi_clk && pssi_de === 1'b0) seen.push_back(pssi_data);
            end
        end
        asserts++; if (!done) begin fails++; $display("FAIL tx_done: tx_ready_o %b want 1 within 60 cycles", tx_ready); end
        asserts++; if (seen.size() != 4 || seen[0] !== 8'hEF || seen[1] !== 8'hBE || seen[2] !== 8'hAD || seen[3] !== 8'hDE) begin
            fails++; $display("FAIL tx_bytes: got %0d bytes %h %h %h %h want 4 bytes ef be ad de", seen.size(),
                              (seen.size() > 0) ? seen[0] : 8'hx, (seen.size() > 1) ? seen[1] : 8'hx,
                              (seen.size() > 2) ? seen[2] : 8'hx, (seen.size() > 3) ? seen[3] : 8'hx);
        end
        asserts++; if (low_cnt != 8) begin fails++; $display("FAIL tx_de_low_cycles: got %0d want 8", low_cnt); end
        asserts++; if (pssi_de !== 1'b1 || pssi_data !== 8'h00) begin
            fails++; $display("FAIL tx_end_idle: got de %b data %h want 1 00", pssi_de, pssi_data);
        end
        asserts++; if (rx_q.size() != 0 || fpga_data !== 32'h44332211) begin
            fails++; $display("FAIL tx_no_rx: got %0d pulses data %h want 0 pulses 44332211", rx_q.size(), fpga_data);
        end
        tx_en  = 1'b0;
        tb_drv = 1'b1;
        tb_de  = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_word();
        rx_q.delete();
        send_beat(1'b0, 8'h55);
        send_beat(1'b0, 8'h66);
        send_beat(1'b0, 8'h77);
        #2 rst_n = 1'b0;
        #1;
        asserts++; if (fpga_data !== 32'h0 || rx_valid !== 1'b0 || pssi_clk !== 1'b0 || tx_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_state: got data %h vld %b clk %b rdy %b want 00000000 0 0 1",
                              fpga_data, rx_valid, pssi_clk, tx_ready);
        end
        tb_de = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(1'b0, 8'h0D);
        send_beat(1'b0, 8'h0C);
        send_beat(1'b0, 8'h0B);
        send_beat(1'b0, 8'h0A);
        end_burst();
        asserts++; if (rx_q.size() != 1 || rx_q[0] !== 32'h0A0B0C0D) begin
            fails++; $display("FAIL midreset_next_word: got %0d words first %h want 1 word 0a0b0c0d",
                              rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'hx);
        end
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_abort_partial();
        test_tx();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
